// File: rtl/psm_phase_ctrl.sv
// Phase-shift modulation controller: a reference square-wave leg and a delayed
// leg built from one carrier counter, with shadowed period/phase/dead-time registers.
module psm_phase_ctrl #(
    parameter int unsigned BITS_DATA = 8,
    parameter int unsigned BITS_PER  = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 iEN,
    input  logic                 iFAULT,
    input  logic                 iFAULT_CLR,
    input  logic [BITS_PER-1:0]  iPERIOD,
    input  logic [BITS_PER-1:0]  iPHASE,
    input  logic [BITS_DATA-1:0] iDT,
    input  logic                 iLOAD,
    output logic                 oPSM_REF,
    output logic                 oPSM_SH,
    output logic [BITS_DATA-1:0] oSHIFT,
    output logic                 oRUN,
    output logic                 oFAULT,
    output logic                 oLOAD_ACK
);

    localparam logic [BITS_PER-1:0] MIN_PER = BITS_PER'(2);
    localparam logic [BITS_PER-1:0] ONE     = BITS_PER'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        STOP  = 3'd3,
        FAULT = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [BITS_PER-1:0]  cnt_q, cnt_d;

    logic [BITS_PER-1:0]  pend_per_q, pend_ph_q;
    logic [BITS_DATA-1:0] pend_dt_q;
    logic                 upd_q, upd_d;

    logic [BITS_PER-1:0]  act_per_q, act_ph_q;
    logic [BITS_DATA-1:0] act_dt_q;

    logic                 ref_q, ref_d;
    logic                 sh_q, sh_d;
    logic                 run_q, run_d;
    logic                 fault_q, fault_d;
    logic                 ack_q, ack_d;

    logic [BITS_PER-1:0]  clamp_per, clamp_ph;
    logic [BITS_PER-1:0]  half_per, last_cnt, sh_cnt;
    logic                 wrap, carrier_on, apply;

    // Clamped view of the pending values, and carrier-derived quantities
    always_comb begin
        clamp_per  = (pend_per_q < MIN_PER) ? MIN_PER : pend_per_q;
        clamp_ph   = (pend_ph_q >= clamp_per) ? (clamp_per - ONE) : pend_ph_q;
        half_per   = act_per_q >> 1;
        last_cnt   = act_per_q - ONE;
        wrap       = (cnt_q == last_cnt);
        carrier_on = (state_q == RUN) || (state_q == STOP);
        // Subtract first so cnt + (P - D) never exceeds P-1
        sh_cnt     = (cnt_q >= act_ph_q) ? (cnt_q - act_ph_q)
                                         : (cnt_q + (act_per_q - act_ph_q));
    end

    // Next-state logic; a trip overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iEN) state_d = ARM;
            ARM:     state_d = RUN;
            RUN:     if (!iEN) state_d = STOP;
            STOP: begin
                if (iEN) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            FAULT:   if (iFAULT_CLR) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (iFAULT) begin
            state_d = FAULT;
        end
    end

    // Shadow-register application and the outstanding-update flag
    always_comb begin
        apply = 1'b0;
        if (!iFAULT) begin
            case (state_q)
                IDLE:      apply = upd_q;
                ARM:       apply = 1'b1;
                RUN, STOP: apply = upd_q && wrap;
                default:   apply = 1'b0;
            endcase
        end
        ack_d = apply && upd_q;
        upd_d = upd_q;
        if (iLOAD) begin
            upd_d = 1'b1;
        end else if (apply) begin
            upd_d = 1'b0;
        end
    end

    // Carrier counter runs only while staying within RUN/STOP
    always_comb begin
        cnt_d = '0;
        if (carrier_on && ((state_d == RUN) || (state_d == STOP))) begin
            cnt_d = wrap ? '0 : (cnt_q + ONE);
        end
    end

    // Registered outputs; legs lag the counter by one cycle
    always_comb begin
        ref_d   = carrier_on && !iFAULT && (cnt_q < half_per);
        sh_d    = carrier_on && !iFAULT && (sh_cnt < half_per);
        run_d   = (state_d == ARM) || (state_d == RUN) || (state_d == STOP);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            ref_q   <= 1'b0;
            sh_q    <= 1'b0;
            run_q   <= 1'b0;
            fault_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            ref_q   <= ref_d;
            sh_q    <= sh_d;
            run_q   <= run_d;
            fault_q <= fault_d;
            ack_q   <= ack_d;
        end
    end

    // Pending registers hold raw values; clamping happens on application
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_per_q <= MIN_PER;
            pend_ph_q  <= '0;
            pend_dt_q  <= '0;
        end else if (iLOAD) begin
            pend_per_q <= iPERIOD;
            pend_ph_q  <= iPHASE;
            pend_dt_q  <= iDT;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            act_per_q <= MIN_PER;
            act_ph_q  <= '0;
            act_dt_q  <= '0;
        end else if (apply) begin
            act_per_q <= clamp_per;
            act_ph_q  <= clamp_ph;
            act_dt_q  <= pend_dt_q;
        end
    end

    assign oPSM_REF  = ref_q;
    assign oPSM_SH   = sh_q;
    assign oSHIFT    = act_dt_q;
    assign oRUN      = run_q;
    assign oFAULT    = fault_q;
    assign oLOAD_ACK = ack_q;

endmodule

// File: tb/tb_psm_phase_ctrl.sv
// Directed bench for psm_phase_ctrl: a cycle table for the basic run plus
// hand-written sequences for phase shift, shadow update, stop, fault and reset.
module tb_psm_phase_ctrl;

    localparam int unsigned BD = 8;
    localparam int unsigned BP = 16;
    localparam int NVEC = 15;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          iEN, iFAULT, iFAULT_CLR, iLOAD;
    logic [BP-1:0] iPERIOD, iPHASE;
    logic [BD-1:0] iDT;
    logic          oPSM_REF, oPSM_SH, oRUN, oFAULT, oLOAD_ACK;
    logic [BD-1:0] oSHIFT;

    int tests = 0;
    int failed = 0;
    int rel = 0;

    typedef struct {
        logic          en;
        logic          load;
        logic [BP-1:0] per;
        logic [BP-1:0] ph;
        logic [BD-1:0] dt;
        logic          e_ref;
        logic          e_sh;
        logic [BD-1:0] e_shift;
        logic          e_run;
        logic          e_fault;
        logic          e_ack;
    } vec_t;

    vec_t vecs [NVEC];
    logic h_ref [40];
    logic h_sh  [40];

    psm_phase_ctrl #(.BITS_DATA(BD), .BITS_PER(BP)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .iEN        (iEN),
        .iFAULT     (iFAULT),
        .iFAULT_CLR (iFAULT_CLR),
        .iPERIOD    (iPERIOD),
        .iPHASE     (iPHASE),
        .iDT        (iDT),
        .iLOAD      (iLOAD),
        .oPSM_REF   (oPSM_REF),
        .oPSM_SH    (oPSM_SH),
        .oSHIFT     (oSHIFT),
        .oRUN       (oRUN),
        .oFAULT     (oFAULT),
        .oLOAD_ACK  (oLOAD_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (rel cycle %0d): got %0h, expected %0h", name, rel, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        rel++;
    endtask

    task automatic adv_to(input int n);
        while (rel < n) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ref"},   32'(oPSM_REF),  32'd0);
        chk({tag, "_sh"},    32'(oPSM_SH),   32'd0);
        chk({tag, "_shift"}, 32'(oSHIFT),    32'd0);
        chk({tag, "_run"},   32'(oRUN),      32'd0);
        chk({tag, "_fault"}, 32'(oFAULT),    32'd0);
        chk({tag, "_ack"},   32'(oLOAD_ACK), 32'd0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        iEN = 1'b0; iFAULT = 1'b0; iFAULT_CLR = 1'b0; iLOAD = 1'b0;
        iPERIOD = '0; iPHASE = '0; iDT = '0;
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    // Load in IDLE, let IDLE apply it, then enable; returns on the first RUN cycle (cnt=0)
    task automatic launch(input int p, input int d, input int dt);
        iPERIOD = BP'(p); iPHASE = BP'(d); iDT = BD'(dt);
        iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        tick();
        chk("launch_ack", 32'(oLOAD_ACK), 32'd1);
        chk("launch_shift", 32'(oSHIFT), 32'(dt));
        iEN = 1'b1;
        tick();
        chk("arm_run", 32'(oRUN), 32'd1);
        chk("arm_ref", 32'(oPSM_REF), 32'd0);
        tick();
        rel = 0;
    endtask

    task automatic start_run(input int p, input int d, input int dt);
        do_reset();
        launch(p, d, dt);
    endtask

    // Reference leg high for cnt < P/2; shifted leg is the same pattern delayed by dly cycles
    task automatic phase_chk(input int p, input int d, input int dly);
        int c;
        start_run(p, d, 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            h_ref[k] = oPSM_REF;
            h_sh[k]  = oPSM_SH;
        end
        for (int k = 0; k < 40; k++) begin
            c = ((k - dly) % p + p) % p;
            chk("phase_ref", 32'(h_ref[k]), 32'((k % p) < (p / 2)));
            chk("phase_sh",  32'(h_sh[k]),  32'(c < (p / 2)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        // Basic run: P=10, D=0, DT=3; index i is the state after the i-th edge
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].en      = (i >= 2);
            vecs[i].load    = (i == 0);
            vecs[i].per     = BP'(10);
            vecs[i].ph      = BP'(0);
            vecs[i].dt      = BD'(3);
            vecs[i].e_ref   = ((i >= 4) && (i <= 8)) || (i == 14);
            vecs[i].e_sh    = ((i >= 4) && (i <= 8)) || (i == 14);
            vecs[i].e_shift = (i >= 1) ? BD'(3) : BD'(0);
            vecs[i].e_run   = (i >= 2);
            vecs[i].e_fault = 1'b0;
            vecs[i].e_ack   = (i == 1);
        end

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            iEN = vecs[i].en; iLOAD = vecs[i].load;
            iPERIOD = vecs[i].per; iPHASE = vecs[i].ph; iDT = vecs[i].dt;
            tick();
            chk("tbl_ref",   32'(oPSM_REF),  32'(vecs[i].e_ref));
            chk("tbl_sh",    32'(oPSM_SH),   32'(vecs[i].e_sh));
            chk("tbl_shift", 32'(oSHIFT),    32'(vecs[i].e_shift));
            chk("tbl_run",   32'(oRUN),      32'(vecs[i].e_run));
            chk("tbl_fault", 32'(oFAULT),    32'(vecs[i].e_fault));
            chk("tbl_ack",   32'(oLOAD_ACK), 32'(vecs[i].e_ack));
        end

        // Phase shift D=3, and D=12 clamped to 9
        phase_chk(10, 3, 3);
        phase_chk(10, 12, 9);

        // Shadow update: load P=8 at cnt=2, applied at the wrap
        start_run(10, 0, 0);
        adv_to(2);
        iPERIOD = BP'(8); iDT = BD'(3); iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        adv_to(5);  chk("shadow_old_ref", 32'(oPSM_REF), 32'd1);
        adv_to(9);  chk("shadow_ack_pre", 32'(oLOAD_ACK), 32'd0);
        adv_to(10); chk("shadow_ack", 32'(oLOAD_ACK), 32'd1);
                    chk("shadow_shift", 32'(oSHIFT), 32'd3);
                    chk("shadow_ref_wrap", 32'(oPSM_REF), 32'd0);
        adv_to(11); chk("shadow_ack_post", 32'(oLOAD_ACK), 32'd0);
                    chk("shadow_ref_rise", 32'(oPSM_REF), 32'd1);
        adv_to(14); chk("shadow_ref_hi", 32'(oPSM_REF), 32'd1);
        adv_to(15); chk("shadow_ref_lo", 32'(oPSM_REF), 32'd0);
        adv_to(18); chk("shadow_ref_lo2", 32'(oPSM_REF), 32'd0);
        adv_to(19); chk("shadow_ref_next", 32'(oPSM_REF), 32'd1);

        // Load coincident with the wrap waits for the following wrap
        start_run(10, 0, 0);
        adv_to(9);
        iPERIOD = BP'(6); iLOAD = 1'b1;
        adv_to(10); chk("wrapld_ack0", 32'(oLOAD_ACK), 32'd0);
        iLOAD = 1'b0;
        adv_to(11); chk("wrapld_ref_old", 32'(oPSM_REF), 32'd1);
        adv_to(16); chk("wrapld_ref_old_lo", 32'(oPSM_REF), 32'd0);
        adv_to(19); chk("wrapld_ack_pre", 32'(oLOAD_ACK), 32'd0);
        adv_to(20); chk("wrapld_ack", 32'(oLOAD_ACK), 32'd1);
        adv_to(21); chk("wrapld_ref_hi", 32'(oPSM_REF), 32'd1);
        adv_to(23); chk("wrapld_ref_hi2", 32'(oPSM_REF), 32'd1);
        adv_to(24); chk("wrapld_ref_lo", 32'(oPSM_REF), 32'd0);
        adv_to(27); chk("wrapld_ref_next", 32'(oPSM_REF), 32'd1);

        // Stop at cnt=4: period completes, then IDLE
        start_run(10, 0, 0);
        adv_to(4);
        iEN = 1'b0;
        adv_to(5);  chk("stop_run", 32'(oRUN), 32'd1);
                    chk("stop_ref", 32'(oPSM_REF), 32'd1);
        adv_to(6);  chk("stop_ref_lo", 32'(oPSM_REF), 32'd0);
        adv_to(9);  chk("stop_run_last", 32'(oRUN), 32'd1);
        adv_to(10); chk("stop_idle_run", 32'(oRUN), 32'd0);
        adv_to(11); chk("stop_idle_ref", 32'(oPSM_REF), 32'd0);
                    chk("stop_idle_sh", 32'(oPSM_SH), 32'd0);
                    chk("stop_idle_run2", 32'(oRUN), 32'd0);

        // Stop at cnt=4, resume at cnt=7 with no gap
        start_run(10, 0, 0);
        adv_to(4);
        iEN = 1'b0;
        adv_to(7);
        iEN = 1'b1;
        adv_to(8);  chk("resume_run", 32'(oRUN), 32'd1);
        adv_to(10); chk("resume_ref_lo", 32'(oPSM_REF), 32'd0);
                    chk("resume_run2", 32'(oRUN), 32'd1);
        adv_to(11); chk("resume_ref_hi", 32'(oPSM_REF), 32'd1);
        adv_to(15); chk("resume_ref_hi2", 32'(oPSM_REF), 32'd1);
                    chk("resume_run3", 32'(oRUN), 32'd1);

        // Fault: trip, ignored clear, load held off, then clear to IDLE
        start_run(10, 0, 4);
        adv_to(2);  chk("fault_pre_ref", 32'(oPSM_REF), 32'd1);
        iFAULT = 1'b1;
        adv_to(3);  chk("fault_flag", 32'(oFAULT), 32'd1);
                    chk("fault_ref", 32'(oPSM_REF), 32'd0);
                    chk("fault_sh", 32'(oPSM_SH), 32'd0);
                    chk("fault_run", 32'(oRUN), 32'd0);
        iFAULT_CLR = 1'b1; iEN = 1'b0;
        adv_to(4);  chk("fault_clr_ignored", 32'(oFAULT), 32'd1);
        iFAULT_CLR = 1'b0; iFAULT = 1'b0;
        iPERIOD = BP'(6); iDT = BD'(7); iLOAD = 1'b1;
        adv_to(5);  chk("fault_hold", 32'(oFAULT), 32'd1);
                    chk("fault_no_ack", 32'(oLOAD_ACK), 32'd0);
                    chk("fault_shift_kept", 32'(oSHIFT), 32'd4);
        iLOAD = 1'b0;
        adv_to(6);  chk("fault_no_ack2", 32'(oLOAD_ACK), 32'd0);
        iFAULT_CLR = 1'b1;
        adv_to(7);  chk("fault_cleared", 32'(oFAULT), 32'd0);
                    chk("fault_idle_run", 32'(oRUN), 32'd0);
        iFAULT_CLR = 1'b0;
        adv_to(8);  chk("fault_idle_ack", 32'(oLOAD_ACK), 32'd1);
                    chk("fault_idle_shift", 32'(oSHIFT), 32'd7);

        // Asynchronous reset mid-RUN, then P=1 clamps to 2
        start_run(10, 0, 5);
        adv_to(2);  chk("prerst_ref", 32'(oPSM_REF), 32'd1);
                    chk("prerst_shift", 32'(oSHIFT), 32'd5);
        #2;
        RST_N = 1'b0;
        iEN = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        chk("rst_hold_ref", 32'(oPSM_REF), 32'd0);
        RST_N = 1'b1;
        launch(1, 0, 0);
        adv_to(1);  chk("p1_ref_hi", 32'(oPSM_REF), 32'd1);
        adv_to(2);  chk("p1_ref_lo", 32'(oPSM_REF), 32'd0);
                    chk("p1_sh_lo", 32'(oPSM_SH), 32'd0);
        adv_to(3);  chk("p1_ref_hi2", 32'(oPSM_REF), 32'd1);
                    chk("p1_sh_hi2", 32'(oPSM_SH), 32'd1);
        adv_to(4);  chk("p1_ref_lo2", 32'(oPSM_REF), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
